// File: rtl/cic_compensator.sv
// cic_compensator: programmable odd-length FIR that flattens the passband droop of a
// CIC decimator. It uses one multiplier, time-shared over NUM_TAPS cycles per output.
// Samples go into a circular buffer. Every DECIMATION-th accepted sample starts a
// multiply-accumulate pass, followed by a round-half-up to the output width.
// Optional feature macro: CIC_COMPENSATOR_SATURATE_EN. When it is defined, the rounded
// result is clamped to the output range. When it is not defined, the output keeps the
// low bits of the rounded result (two's-complement wrap).

module cic_compensator #(
   parameter int NUM_TAPS        = 15,
   parameter int DECIMATION      = 2,
   parameter int NUM_BITS_INPUT  = 16,
   parameter int NUM_BITS_COEF   = 18,
   parameter int NUM_BITS_OUTPUT = 16
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              tick_i,
   input  logic signed [NUM_BITS_INPUT-1:0]  signal_i,
   input  logic                              coef_we_i,
   input  logic [$clog2(NUM_TAPS)-1:0]       coef_addr_i,
   input  logic signed [NUM_BITS_COEF-1:0]   coef_data_i,
   output logic signed [NUM_BITS_OUTPUT-1:0] signal_o,
   output logic                              tick_o,
   output logic                              busy_o,
   output logic                              overrun_o
);

   localparam int AW     = $clog2(NUM_TAPS);
   localparam int PROD_W = NUM_BITS_INPUT + NUM_BITS_COEF;
   localparam int ACC_W  = PROD_W + AW;
   localparam int DW     = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TAPS - 1);
   localparam logic [DW-1:0] DEC_LAST = DW'(DECIMATION - 1);

   // Largest positive Q1.x value, so coef[0] of the reset set is "almost 1.0".
   localparam logic signed [NUM_BITS_COEF-1:0] COEF_ONE = {1'b0, {(NUM_BITS_COEF-1){1'b1}}};

   // Rounding works one bit wider than acc, so adding the half-LSB cannot overflow.
   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2**(NUM_BITS_COEF-2));
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(2**(NUM_BITS_OUTPUT-1) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(2**(NUM_BITS_OUTPUT-1)));

   typedef enum logic [1:0] {StIdle, StMac, StRound} state_e;

   state_e                              r_state;
   state_e                              w_state_next;
   logic signed [NUM_BITS_INPUT-1:0]    r_buf  [NUM_TAPS];
   logic signed [NUM_BITS_COEF-1:0]     r_coef [NUM_TAPS];
   logic [AW-1:0]                       r_wr_ptr;
   logic [AW-1:0]                       r_rd_ptr;
   logic [AW-1:0]                       r_tap;
   logic [DW-1:0]                       r_dec_cnt;
   logic signed [ACC_W-1:0]             r_acc;

   logic                                w_accept;
   logic                                w_start;
   logic signed [PROD_W-1:0]            w_product;
   logic signed [ACC_W:0]               w_rnd_sum;
   logic signed [ACC_W:0]               w_rnd;
   logic signed [NUM_BITS_OUTPUT-1:0]   w_out;

   assign busy_o = (r_state != StIdle);

   // Next state. A sample is accepted only in idle; the last sample of each decimation
   // group starts a computation.
   always_comb begin
      w_accept     = tick_i && (r_state == StIdle);
      w_start      = w_accept && (r_dec_cnt == DEC_LAST);
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_start) w_state_next = StMac;
         StMac:   if (r_tap == LAST_IDX) w_state_next = StRound;
         StRound: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   // Sample buffer, write pointer and decimation phase. These advance only on accepted ticks.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_TAPS; i++) r_buf[i] <= '0;
         r_wr_ptr  <= '0;
         r_dec_cnt <= '0;
      end else if (w_accept) begin
         r_buf[r_wr_ptr] <= signal_i;
         r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
         r_dec_cnt       <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + 1'b1;
      end
   end

   // Coefficient RAM. Writes are honoured only in idle, so a pass never mixes coefficient sets.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= (i == 0) ? COEF_ONE : '0;
      end else if (coef_we_i && (r_state == StIdle) && (coef_addr_i <= LAST_IDX)) begin
         r_coef[coef_addr_i] <= coef_data_i;
      end
   end

   assign w_product = PROD_W'(r_coef[r_tap]) * PROD_W'(r_buf[r_rd_ptr]);

   // MAC sequencer. The read pointer starts at the triggering sample and walks back in time.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_acc    <= '0;
         r_tap    <= '0;
         r_rd_ptr <= '0;
      end else if (r_state == StIdle) begin
         if (w_start) begin
            r_acc    <= '0;
            r_tap    <= '0;
            r_rd_ptr <= r_wr_ptr;
         end
      end else if (r_state == StMac) begin
         r_acc    <= r_acc + ACC_W'(w_product);
         r_tap    <= r_tap + 1'b1;
         r_rd_ptr <= (r_rd_ptr == '0) ? LAST_IDX : r_rd_ptr - 1'b1;
      end
   end

   assign w_rnd_sum = {r_acc[ACC_W-1], r_acc} + RND_HALF;
   assign w_rnd     = w_rnd_sum >>> (NUM_BITS_COEF - 1);

   // Output conversion. Either clamp or wrap the rounded value to the output width.
   always_comb begin
      w_out = '0;
`ifdef CIC_COMPENSATOR_SATURATE_EN
      if (w_rnd > SAT_MAX)      w_out = SAT_MAX[NUM_BITS_OUTPUT-1:0];
      else if (w_rnd < SAT_MIN) w_out = SAT_MIN[NUM_BITS_OUTPUT-1:0];
      else                      w_out = w_rnd[NUM_BITS_OUTPUT-1:0];
`else
      w_out = NUM_BITS_OUTPUT'(w_rnd);
`endif
   end

   // Output register and one-cycle strobe. Both are loaded only when the ROUND cycle completes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         signal_o <= '0;
         tick_o   <= 1'b0;
      end else begin
         tick_o <= (r_state == StRound);
         if (r_state == StRound) signal_o <= w_out;
      end
   end

   // Sticky overrun flag. It is set by any tick that arrives while a computation is in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i)                         overrun_o <= 1'b0;
      else if (tick_i && r_state != StIdle) overrun_o <= 1'b1;
   end

endmodule

// File: tb/tb_cic_compensator.sv
// Scoreboard bench for cic_compensator. dut0 uses the default parameters; dut1 uses DECIMATION=1.
// Stimulus pushes the expected output value and its arrival cycle into a queue. A monitor pops
// an entry each time the DUT raises tick_o and compares value and latency.

module tb_cic_compensator;

   localparam int N = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                reset;
   logic                tick0, we0, tick1, we1;
   logic signed [15:0]  sig0, sig1;
   logic [3:0]          addr0, addr1;
   logic signed [17:0]  data0, data1;
   logic signed [15:0]  sig0_o, sig1_o;
   logic                tick0_o, busy0, ovr0, tick1_o, busy1, ovr1;

   cic_compensator u_dut0 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick0), .signal_i(sig0), .coef_we_i(we0),
      .coef_addr_i(addr0), .coef_data_i(data0), .signal_o(sig0_o), .tick_o(tick0_o),
      .busy_o(busy0), .overrun_o(ovr0)
   );

   cic_compensator #(.DECIMATION(1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick1), .signal_i(sig1), .coef_we_i(we1),
      .coef_addr_i(addr1), .coef_data_i(data1), .signal_o(sig1_o), .tick_o(tick1_o),
      .busy_o(busy1), .overrun_o(ovr1)
   );

   typedef struct { int val; longint cyc; int tag; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int n_vec = 0;
   int n_err = 0;
   int tag0 = 0;
   int tag1 = 0;

   function automatic void check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Reference model for dut0: a direct convolution over the accepted-sample history.
   logic signed [17:0] m_coef [N];
   int     m_hist[$];
   int     m_cnt;
   longint m_idle_at;
   bit     m_ovr;

   function automatic void model_reset();
      for (int k = 0; k < N; k++) m_coef[k] = (k == 0) ? 18'sd131071 : 18'sd0;
      m_hist.delete();
      m_cnt     = 0;
      m_idle_at = 0;
      m_ovr     = 1'b0;
   endfunction

   function automatic int model_out();
      longint s = 0;
      longint r;
      for (int k = 0; k < N; k++) begin
         int idx = m_hist.size() - 1 - k;
         if (idx >= 0) s += longint'(m_coef[k]) * longint'(m_hist[idx]);
      end
      r = (s + 64'sd65536) >>> 17;
`ifdef CIC_COMPENSATOR_SATURATE_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`else
      r = r & 64'hFFFF;
      if (r > 32767) r = r - 65536;
`endif
      return int'(r);
   endfunction

   task automatic drive0(input bit tk, input int smp, input bit we, input int adr, input int dat);
      bit idle;
      idle  = (cyc >= m_idle_at);
      check("dut0 busy_o", longint'(busy0), longint'(!idle));
      tick0 = tk;
      sig0  = 16'(smp);
      we0   = we;
      addr0 = 4'(adr);
      data0 = 18'(dat);
      if (we && idle && adr < N) m_coef[adr] = 18'(dat);
      if (tk) begin
         if (idle) begin
            m_hist.push_back(smp);
            if (m_cnt == 1) begin
               q0.push_back('{val: model_out(), cyc: cyc + N + 2, tag: tag0});
               tag0++;
               m_idle_at = cyc + N + 2;
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end else begin
            m_ovr = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      tick0 = 1'b0;
      we0   = 1'b0;
   endtask

   task automatic drive1(input bit tk, input int smp, input bit we, input int adr, input int dat,
                         input bit push, input int expv);
      tick1 = tk;
      sig1  = 16'(smp);
      we1   = we;
      addr1 = 4'(adr);
      data1 = 18'(dat);
      if (push) begin
         q1.push_back('{val: expv, cyc: cyc + N + 2, tag: tag1});
         tag1++;
      end
      @(posedge clk);
      #1;
      tick1 = 1'b0;
      we1   = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // dut0 monitor
   always @(negedge clk) begin
      exp_t e;
      if (tick0_o) begin
         if (q0.size() == 0) begin
            check("dut0 tick_o with nothing expected", longint'(tick0_o), 0);
         end else begin
            e = q0.pop_front();
            check($sformatf("dut0 out%0d value", e.tag), longint'(sig0_o), longint'(e.val));
            check($sformatf("dut0 out%0d latency", e.tag), cyc, e.cyc);
         end
      end
   end

   // dut1 monitor
   always @(negedge clk) begin
      exp_t e;
      if (tick1_o) begin
         if (q1.size() == 0) begin
            check("dut1 tick_o with nothing expected", longint'(tick1_o), 0);
         end else begin
            e = q1.pop_front();
            check($sformatf("dut1 out%0d value", e.tag), longint'(sig1_o), longint'(e.val));
            check($sformatf("dut1 out%0d latency", e.tag), cyc, e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      longint c0;
      reset = 1'b1;
      tick0 = 1'b0; we0 = 1'b0; sig0 = '0; addr0 = '0; data0 = '0;
      tick1 = 1'b0; we1 = 1'b0; sig1 = '0; addr1 = '0; data1 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset signal_o", longint'(sig0_o), 0);
      check("reset tick_o", longint'(tick0_o), 0);
      check("reset busy_o", longint'(busy0), 0);
      check("reset overrun_o", longint'(ovr0), 0);

      // Identity passthrough of a constant input; tick_i arrives every 20 clocks.
      for (int i = 0; i < 8; i++) begin
         drive0(1'b1, 1000, 1'b0, 0, 0);
         idle_cycles(19);
      end
      check("constant 1000 passthrough", longint'(sig0_o), 1000);

      // Add a half-weight second tap, so a stray buffered sample would change the result.
      drive0(1'b0, 0, 1'b1, 1, 65536);
      drive0(1'b1, 100, 1'b0, 0, 0);
      idle_cycles(19);
      drive0(1'b1, 500, 1'b0, 0, 0);      // triggers
      idle_cycles(4);
      drive0(1'b1, 777, 1'b0, 0, 0);      // 5 clocks later: dropped
      check("overrun_o after dropped tick", longint'(ovr0), longint'(m_ovr));
      idle_cycles(20);
      drive0(1'b1, 300, 1'b0, 0, 0);
      idle_cycles(19);
      drive0(1'b1, 400, 1'b0, 0, 0);      // 400*~1 + 300*0.5
      idle_cycles(19);
      check("output after drop", longint'(sig0_o), 550);

      // A coefficient write during MAC is ignored. The same write in idle, on the same cycle
      // as the triggering tick, takes effect for that computation.
      drive0(1'b1, 1000, 1'b0, 0, 0);
      idle_cycles(19);
      drive0(1'b1, 2000, 1'b0, 0, 0);     // triggers
      idle_cycles(4);
      drive0(1'b0, 0, 1'b1, 0, 0);        // write during MAC
      idle_cycles(20);
      check("coef write in MAC ignored", longint'(sig0_o), 2500);
      drive0(1'b1, 3000, 1'b0, 0, 0);
      idle_cycles(19);
      drive0(1'b1, 4000, 1'b1, 0, 0);     // write coef0=0 together with the trigger
      idle_cycles(19);
      check("coef write in idle applied", longint'(sig0_o), 1500);
      check("overrun_o still held", longint'(ovr0), 1);

      // Reset in MAC cycle 5 aborts the computation.
      drive0(1'b1, 10, 1'b0, 0, 0);
      idle_cycles(19);
      c0 = cyc;
      drive0(1'b1, 20, 1'b0, 0, 0);       // triggers in cycle c0
      idle_cycles(4);
      check("busy_o in MAC", longint'(busy0), 1);
      reset = 1'b1;                       // held through MAC cycle c0+5
      @(posedge clk);
      #1;
      reset = 1'b0;
      q0.delete();
      model_reset();
      check("abort: reset cycle", cyc, c0 + 6);
      idle_cycles(25);
      check("abort signal_o", longint'(sig0_o), 0);
      check("abort busy_o", longint'(busy0), 0);
      check("abort overrun_o cleared", longint'(ovr0), 0);
      drive0(1'b1, -1234, 1'b0, 0, 0);
      idle_cycles(19);
      drive0(1'b1, -1234, 1'b0, 0, 0);
      idle_cycles(19);
      check("identity restored", longint'(sig0_o), -1234);

      // All coefficients at full scale with a full-scale input: wraps, or clamps when enabled.
      for (int k = 0; k < N; k++) drive0(1'b0, 0, 1'b1, k, 131071);
      for (int i = 0; i < 16; i++) begin
         drive0(1'b1, 32767, 1'b0, 0, 0);
         idle_cycles(19);
      end
`ifdef CIC_COMPENSATOR_SATURATE_EN
      check("full-scale saturate", longint'(sig0_o), 32767);
`else
      check("full-scale wrap", longint'(sig0_o), 32749);
`endif

      // DECIMATION=1 impulse response with a ramp of coefficients.
      for (int k = 0; k < N; k++) drive1(1'b0, 0, 1'b1, k, 1024 * (k + 1), 1'b0, 0);
      for (int i = 0; i < 16; i++) begin
         drive1(1'b1, (i == 0) ? 16384 : 0, 1'b0, 0, 0, 1'b1, (i < N) ? 128 * (i + 1) : 0);
         idle_cycles(19);
      end
      check("dut1 overrun_o", longint'(ovr1), 0);

      idle_cycles(30);
      check("dut0 outputs outstanding", longint'(q0.size()), 0);
      check("dut1 outputs outstanding", longint'(q1.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
